apb_master_bridge: RTL
======================

// Module: apb_master_bridge
// PURPOSE
//  Upstream APB master for the on-chip SRAM controller path. Accepts single read/write requests
//  on a valid/ready request channel, runs one APB transfer (SETUP -> ACCESS, waits on pready),
//  returns read data/status on a valid/ready response channel. One transfer outstanding at a time.
// PARAMETERS
//  DATA_WIDTH      8    data width of request, response and APB data buses
//  ADDR_WIDTH      32   address width of request and paddr
//  TIMEOUT_CYCLES  16   ACCESS cycles without pready before abort (used only with APB_TIMEOUT_EN)
// PORTS
//  clk        in   1           clock
//  rstn       in   1           reset, asynchronous, active-low
//  req_valid  in   1           request present
//  req_ready  out  1           bridge accepts request (IDLE only)
//  req_addr   in   ADDR_WIDTH  transfer address
//  req_write  in   1           1=write, 0=read
//  req_wdata  in   DATA_WIDTH  write data
//  rsp_valid  out  1           response present
//  rsp_ready  in   1           response consumer ready
//  rsp_rdata  out  DATA_WIDTH  read data (0 for writes and timeouts)
//  rsp_err    out  1           1 = transfer aborted by timeout
//  psel       out  1           APB select
//  penable    out  1           APB enable
//  paddr      out  ADDR_WIDTH  APB address
//  pwrite     out  1           APB direction
//  pwdata     out  DATA_WIDTH  APB write data
//  pready     in   1           APB slave ready
//  prdata     in   DATA_WIDTH  APB read data
// BEHAVIOUR
//  - Reset (rstn low, async): state=IDLE; psel=penable=0; paddr,pwrite,pwdata=0; rsp_valid=0,
//    rsp_rdata=0, rsp_err=0; timeout counter=0. req_ready=1 once in IDLE.
//  - FSM states IDLE, SETUP, ACCESS, RESP:
//    IDLE  : req_ready=1. req_valid&req_ready -> latch addr/write/wdata into paddr/pwrite/pwdata; -> SETUP.
//    SETUP : psel=1, penable=0, exactly one cycle; -> ACCESS.
//    ACCESS: psel=1, penable=1; paddr/pwrite/pwdata held stable. pready=1 -> capture prdata into
//            rsp_rdata (writes: rsp_rdata=0), rsp_err=0, rsp_valid=1; -> RESP. pready=0 -> stay.
//    RESP  : psel=penable=0; rsp_valid held with stable data until rsp_valid&rsp_ready; then -> IDLE,
//            rsp_valid=0. No new request accepted before the response handshake completes.
//  - psel/penable/req_ready decoded from state registers only; no combinational path from pready/req_valid.
//  - Latency: request accepted at edge N; SETUP cycle N+1; first ACCESS cycle N+2; with pready on
//    ACCESS cycle k, rsp_valid=1 from cycle k+1. Min request->rsp_valid = 3 cycles.
//  - pready outside ACCESS ignored. prdata sampled only in ACCESS with pready=1.
//  - rstn asserted mid-transfer: psel/penable drop immediately, pending response discarded.
// CONFIGURATION
//  - APB_TIMEOUT_EN defined: counter clears on SETUP entry, increments each ACCESS cycle with pready=0;
//    when count reaches TIMEOUT_CYCLES, -> RESP with rsp_err=1, rsp_rdata=0, psel/penable deasserted.
//    pready on the same cycle as the terminal count wins (normal completion, rsp_err=0).
//  - Not defined: no counter; ACCESS waits indefinitely; rsp_err tied 0.
// STRUCTURE
//  - Package apb_bridge_pkg: state encoding localparams (IDLE=0,SETUP=1,ACCESS=2,RESP=3), state width.
//  - One sub-module apb_timeout_cnt (clear, enable, terminal-count flag), instantiated only under APB_TIMEOUT_EN.
// TESTING
//  - Write 0xA5 to 0x0000_0010 against SRAM controller (1 wait state) -> psel 3 cycles, penable 2,
//    pwrite=1, SRAM addr 0x10 = 0xA5, rsp_valid with rsp_err=0, rsp_rdata=0.
//  - Read back 0x0000_0010 -> rsp_rdata=0xA5, rsp_valid 4 cycles after request accept.
//  - Zero-wait slave model (pready=1 always) -> rsp_valid 3 cycles after accept; back-to-back requests
//    with rsp_ready=1 -> req_ready low from accept through response handshake, one IDLE cycle between.
//  - Hold rsp_ready=0 for 5 cycles after read -> rsp_valid/rsp_rdata stable, req_ready=0, psel=0.
//  - APB_TIMEOUT_EN, TIMEOUT_CYCLES=4, pready stuck 0 -> exactly 4 ACCESS cycles, rsp_err=1, rsp_rdata=0;
//    pready on 4th cycle -> rsp_err=0, data captured.
//  - rstn low during ACCESS -> psel=penable=rsp_valid=0 same cycle; after release req_ready=1, next read correct.

Source files
------------

// File: rtl/apb_bridge_pkg.sv
// Shared state encoding for the APB master bridge.
package apb_bridge_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] S_IDLE   = 2'd0;
  localparam logic [STATE_W-1:0] S_SETUP  = 2'd1;
  localparam logic [STATE_W-1:0] S_ACCESS = 2'd2;
  localparam logic [STATE_W-1:0] S_RESP   = 2'd3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = S_IDLE,
    ST_SETUP  = S_SETUP,
    ST_ACCESS = S_ACCESS,
    ST_RESP   = S_RESP
  } state_e;

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase wait counter; o_tc flags the enabled cycle on which the count reaches LIMIT.
module apb_timeout_cnt #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tc
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Flag the cycle whose increment would make the count equal LIMIT, so the
  // FSM leaves ACCESS after exactly LIMIT stalled cycles.
  assign o_tc = i_en && (r_cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding request/response to APB master bridge.
// Optional ACCESS timeout abort when APB_TIMEOUT_EN is defined.
module apb_master_bridge
  import apb_bridge_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_write,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  psel,
  output logic                  penable,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready,
  input  logic [DATA_WIDTH-1:0] prdata
);

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic                  r_pwrite;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  w_timeout;

  // Handshake and bus-phase strobes depend on the state register alone.
  assign req_ready = (r_state == ST_IDLE);
  assign psel      = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
  assign penable   = (r_state == ST_ACCESS);

`ifdef APB_TIMEOUT_EN
  logic r_rsp_err;

  apb_timeout_cnt #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk    (clk),
    .rstn   (rstn),
    .i_clear((r_state == ST_IDLE) && req_valid),
    .i_en   ((r_state == ST_ACCESS) && !pready),
    .o_tc   (w_timeout)
  );

  assign rsp_err = r_rsp_err;
`else
  logic w_unused_timeout_cfg;

  assign w_timeout            = 1'b0;
  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign rsp_err              = 1'b0;
`endif

  // NOTE: every register here is updated with <= so all next-state values are
  // computed from the same pre-edge snapshot; the async reset term keeps the
  // APB strobes and any pending response cleared without waiting for a clock.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
`ifdef APB_TIMEOUT_EN
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            r_paddr  <= req_addr;
            r_pwrite <= req_write;
            r_pwdata <= req_wdata;
            r_state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // pready beats a coincident terminal count.
          if (pready) begin
            r_rsp_rdata <= r_pwrite ? '0 : prdata;
            r_rsp_valid <= 1'b1;
`ifdef APB_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
`endif
            r_state     <= ST_RESP;
          end else if (w_timeout) begin
            r_rsp_rdata <= '0;
            r_rsp_valid <= 1'b1;
`ifdef APB_TIMEOUT_EN
            r_rsp_err   <= 1'b1;
`endif
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign paddr     = r_paddr;
  assign pwrite    = r_pwrite;
  assign pwdata    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;

endmodule
